// File: rtl/freq_meter_pkg.sv
// ============================================================================
// Module      : freq_meter_pkg
// Description : Shared types and sizing helper for the frequency meter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package freq_meter_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Gate counter must hold both the result width and GATE_CYCLES-1.
    function automatic int gate_cnt_width(input int gate_cycles, input int cnt_w);
        int w_clog;
        w_clog = $clog2(gate_cycles);
        return (cnt_w > w_clog) ? cnt_w : w_clog;
    endfunction

endpackage

`default_nettype wire

// File: rtl/freq_meter_edge_sync.sv
// ============================================================================
// Module      : edge_sync
// Description : Two-flop synchronizer followed by a rising-edge detector.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_out
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign edge_out = r_sync2 & ~r_sync3;

endmodule

`default_nettype wire

// File: rtl/freq_meter.sv
// ============================================================================
// Module      : freq_meter
// Description : Counts rising edges of an async input over a fixed clk gate.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 28,
    parameter bit CONTINUOUS  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow
);

    localparam int               GW          = gate_cnt_width(GATE_CYCLES, CNT_W);
    localparam logic [GW-1:0]    C_GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [GW-1:0]     r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_freq;
    logic              r_freq_valid;
    logic              r_overflow;

    logic              w_edge;
    logic              w_measuring;
    logic              w_last;
    logic              w_sat;
    logic [CNT_W-1:0]  w_cnt_inc;

    edge_sync u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sig_in),
        .edge_out (w_edge)
    );

    assign w_measuring = (r_state == MEASURE);
    assign w_last      = w_measuring && (r_gate_cnt == C_GATE_LAST);
    // An edge arriving with the count already at max is the overflow event.
    assign w_sat       = w_edge && (r_edge_cnt == C_CNT_MAX);
    assign w_cnt_inc   = (w_edge && !w_sat) ? (r_edge_cnt + CNT_W'(1)) : r_edge_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (CONTINUOUS || start) begin
                    w_state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (w_last && !CONTINUOUS) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = w_measuring;
    end

    // The last gate cycle both publishes the result and seeds the next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (w_measuring) begin
            if (w_last) begin
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_ovf      <= 1'b0;
            end else begin
                r_gate_cnt <= r_gate_cnt + GW'(1);
                r_edge_cnt <= w_cnt_inc;
                r_ovf      <= r_ovf | w_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_freq       <= '0;
            r_freq_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_freq_valid <= w_last;
            if (w_last) begin
                r_freq     <= w_cnt_inc;
                r_overflow <= r_ovf | w_sat;
            end
        end
    end

    assign freq       = r_freq;
    assign freq_valid = r_freq_valid;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an asynchronous input `sig_in` against the system clock. This is the inverse of our clock divider: the divider derives a slow clock from `clk`, and this block counts external edges during a fixed gate window derived from `clk`.
- Gate window defaults to 1 s at 50 MHz, so the result reads directly in Hz.
- Sits next to the divider and feeds the display/readout logic.

Parameters:
- GATE_CYCLES, 50_000_000, clk cycles per measurement window (minimum 4).
- CNT_W, 28, width of the `freq` result and of the gate counter; the gate counter width is max(CNT_W, clog2(GATE_CYCLES)).
- CONTINUOUS, 1, 1 = back-to-back windows after reset; 0 = one window per `start` pulse.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sig_in  in  1  asynchronous signal under measurement.
- start  in  1  single-shot trigger; used only when CONTINUOUS=0.
- busy  out  1  high while a window is open.
- freq  out  CNT_W  rising-edge count of the last completed window (Hz at default parameters).
- freq_valid  out  1  one-cycle pulse when `freq` updates.
- overflow  out  1  the last window saturated; updated together with `freq`.

Behaviour:
- Reset (synchronous, dominates every other input): `freq`=0, `freq_valid`=0, `overflow`=0, `busy`=0, all counters=0, synchronizer flops=0, state=IDLE.
- Input path: 2-flop synchronizer, then a rising-edge detector with one more flop. `edge` = sync2 & ~sync3. An edge at `sig_in` is counted 3 cycles later. A `sig_in` already high at reset release produces one edge after sync (sync3 resets to 0); the bench must account for this.
- Edge timing: edges arriving during the first 3 cycles of a window count toward that window; no edges are lost between continuous windows.
- States:
  - IDLE: CONTINUOUS=1 goes to MEASURE on the cycle after reset deasserts. CONTINUOUS=0 goes to MEASURE on the cycle after `start`=1.
  - MEASURE: `busy`=1. `gate_cnt` counts 0..GATE_CYCLES-1. `edge_cnt` increments on each `edge`, saturating at 2^CNT_W-1; the saturation sets an internal ovf flag.
    - On the cycle with `gate_cnt`==GATE_CYCLES-1 (the edge on this cycle is included), the next cycle gets: `freq` = edge_cnt (+1 if edge, saturated), `overflow` = ovf (or the saturation on this last cycle), `freq_valid`=1.
    - Also on that cycle: `gate_cnt`, `edge_cnt` and ovf clear.
    - Then CONTINUOUS=1 stays in MEASURE (next window starts immediately, no dead cycle); CONTINUOUS=0 goes to IDLE.
- Outputs:
  - `busy`=0 in IDLE.
  - `freq_valid` is high exactly one cycle per window.
  - `freq` and `overflow` hold between updates.
- `start` while busy: ignored, with no restart or extension of the window. `start` in CONTINUOUS=1: ignored.
- Reset mid-window: the partial count is discarded, no `freq_valid` is issued, and the previous `freq` is cleared to 0.
- Maximum countable rate: clk/2 (`sig_in` period 2 clk). Faster input aliases; that is out of spec.
- Gate counter: compares with == only; no wrap beyond GATE_CYCLES-1.

Decomposition:
- Package `freq_meter_pkg`: state enum {IDLE, MEASURE}, and a helper function for the gate counter width (clog2).
- One sub-module, `edge_sync`: 2-flop synchronizer plus rising-edge detector, ports `clk`, `rst`, `async_in`, `edge_out`. The FSM, counters and result registers stay in `freq_meter`.

Test Plan (GATE_CYCLES=100, CNT_W=8 unless noted):
- Reset: hold `rst` 5 cycles with `sig_in` toggling -> `freq`=0, `freq_valid`=0, `overflow`=0, `busy`=0 throughout. CONTINUOUS=1 -> `busy`=1 on the first cycle after release.
- `sig_in` period 10 clk, CONTINUOUS=1 -> from the second window on, `freq`=10 and `overflow`=0; `freq_valid` pulses exactly every 100 cycles, 1 cycle wide.
- `sig_in` period 2 clk (maximum rate) -> `freq`=50. `sig_in` held 0 or held 1 -> `freq`=0 (after the one possible post-reset edge window).
- CNT_W=4, `sig_in` period 4 -> `freq`=15, `overflow`=1. Then period 10 -> next window gives `freq`=10, `overflow`=0.
- CONTINUOUS=0, period 5:
  - `start` pulse -> `busy` high 100 cycles, then one `freq_valid` with `freq`=20, then `busy`=0.
  - `start` re-pulsed at cycle 50 -> ignored, window length unchanged.
- `rst` at cycle 60 of a window -> no `freq_valid`; `freq`=0. The next window runs a full 100 cycles and reports the correct count.
